// File: rtl/ad9361_tx_pkg.sv
// Shared definitions for the AD9361 TX burst shaper.
//   tx_state_e   : burst-shaper state encoding
//   GAP_CNT_W    : width of the inter-burst gap strobe counter
//   ramp_cnt_w() : ramp counter width; holds 0..2^log2_len inclusive
//   in_burst()   : states during which tx_active is asserted
package ad9361_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP_UP,
    ST_BODY,
    ST_RAMP_DOWN,
    ST_GAP
  } tx_state_e;

  localparam int GAP_CNT_W = 8;

  function automatic int ramp_cnt_w(input int log2_len);
    return log2_len + 1;
  endfunction

  function automatic logic in_burst(input tx_state_e s);
    return (s == ST_RAMP_UP) || (s == ST_BODY) || (s == ST_RAMP_DOWN);
  endfunction

endpackage

// File: rtl/ad9361_tx_ramp_mul.sv
// Combinational ramp gain for one I/Q pair: y = (x * gain) >>> LOG2_RAMP_LENGTH.
//   x_i, x_q : signed input sample
//   gain     : unsigned gain 0..2^LOG2_RAMP_LENGTH (full scale is identity)
//   y_i, y_q : scaled sample; gain never exceeds full scale, so no overflow
module ad9361_tx_ramp_mul
  import ad9361_tx_pkg::*;
#(
  parameter int DATA_WIDTH       = 12,
  parameter int LOG2_RAMP_LENGTH = 3
) (
  input  logic signed [DATA_WIDTH-1:0]                    x_i,
  input  logic signed [DATA_WIDTH-1:0]                    x_q,
  input  logic        [ramp_cnt_w(LOG2_RAMP_LENGTH)-1:0]  gain,
  output logic signed [DATA_WIDTH-1:0]                    y_i,
  output logic signed [DATA_WIDTH-1:0]                    y_q
);

  localparam int GW = ramp_cnt_w(LOG2_RAMP_LENGTH);
  localparam int PW = DATA_WIDTH + LOG2_RAMP_LENGTH + 1;

  // Arithmetic shift floors toward -inf; the truncating cast is exact.
  function automatic logic signed [DATA_WIDTH-1:0] scale(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic        [GW-1:0]         g
  );
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] ge;
    logic signed [PW-1:0] prod;
    xe   = {{(PW-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
    ge   = {{(PW-GW){1'b0}}, g};
    prod = xe * ge;
    return DATA_WIDTH'(prod >>> LOG2_RAMP_LENGTH);
  endfunction

  assign y_i = scale(x_i, gain);
  assign y_q = scale(x_q, gain);

endmodule

// File: rtl/ad9361_tx_burst_shaper.sv
// AD9361 TX burst shaper: pulls I/Q samples one per DAC strobe, applies a
// linear ramp-up at burst start, a ramp-down tail on the last sample, then
// a zero-filled gap of MIN_GAP strobes before the next burst.
//   clk, rst            : clock, asynchronous active-high reset
//   dac_strobe          : request for one DAC sample
//   s_valid/s_ready     : upstream handshake (s_ready is combinational)
//   s_data_i/q, s_last  : upstream sample and end-of-burst marker
//   valid_out           : registered copy of dac_strobe
//   data_i/q_out        : shaped sample to DAC
//   tx_active           : burst (including ramp-down) in progress
//   underrun            : pulse when a mid-burst strobe found no sample
module ad9361_tx_burst_shaper
  import ad9361_tx_pkg::*;
#(
  parameter int DATA_WIDTH       = 12,
  parameter int LOG2_RAMP_LENGTH = 3,
  parameter int MIN_GAP          = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dac_strobe,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_data_i,
  input  logic signed [DATA_WIDTH-1:0] s_data_q,
  input  logic                         s_last,
  output logic                         valid_out,
  output logic signed [DATA_WIDTH-1:0] data_i_out,
  output logic signed [DATA_WIDTH-1:0] data_q_out,
  output logic                         tx_active,
  output logic                         underrun
);

  localparam int            RW    = ramp_cnt_w(LOG2_RAMP_LENGTH);
  localparam logic [RW-1:0] R_VAL = RW'(1 << LOG2_RAMP_LENGTH);
  localparam logic [RW-1:0] ONE   = RW'(1);

  tx_state_e                   state, state_nxt;
  logic [RW-1:0]               k_cnt, k_nxt;
  logic [RW-1:0]               j_cnt, j_nxt;
  logic [GAP_CNT_W-1:0]        gap_cnt, gap_nxt;
  logic signed [DATA_WIDTH-1:0] held_i, held_q;
  logic signed [DATA_WIDTH-1:0] x_i_p0, x_q_p0;
  logic signed [DATA_WIDTH-1:0] y_i_p0, y_q_p0;
  logic [RW-1:0]               gain_p0;
  logic                        take, urun_p0, act_p0;

  assign s_ready = dac_strobe & ~rst &
                   ((state == ST_IDLE) | (state == ST_RAMP_UP) | (state == ST_BODY));
  assign take    = s_valid & s_ready;

  // Stage 0: next-state, gain and operand selection
  always_comb begin
    state_nxt = state;
    k_nxt     = k_cnt;
    j_nxt     = j_cnt;
    gap_nxt   = gap_cnt;
    gain_p0   = '0;
    x_i_p0    = '0;
    x_q_p0    = '0;
    urun_p0   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (take) begin
          gain_p0 = ONE;
          x_i_p0  = s_data_i;
          x_q_p0  = s_data_q;
          k_nxt   = ONE;
          j_nxt   = '0;
          state_nxt = s_last ? ST_RAMP_DOWN : ST_RAMP_UP;
        end
      end
      ST_RAMP_UP: begin
        if (take) begin
          gain_p0 = k_cnt + ONE;
          x_i_p0  = s_data_i;
          x_q_p0  = s_data_q;
          k_nxt   = k_cnt + ONE;
          // s_last wins over completing the ramp
          if (s_last) begin
            state_nxt = ST_RAMP_DOWN;
            j_nxt     = '0;
          end else if (k_cnt + ONE == R_VAL) begin
            state_nxt = ST_BODY;
          end
        end else if (dac_strobe) begin
          urun_p0 = 1'b1;
        end
      end
      ST_BODY: begin
        if (take) begin
          gain_p0 = R_VAL;
          x_i_p0  = s_data_i;
          x_q_p0  = s_data_q;
          if (s_last) begin
            state_nxt = ST_RAMP_DOWN;
            j_nxt     = '0;
          end
        end else if (dac_strobe) begin
          urun_p0 = 1'b1;
        end
      end
      ST_RAMP_DOWN: begin
        if (dac_strobe) begin
          gain_p0 = R_VAL - ONE - j_cnt;
          x_i_p0  = held_i;
          x_q_p0  = held_q;
          j_nxt   = j_cnt + ONE;
          if (gain_p0 == '0) begin
            gap_nxt   = '0;
            state_nxt = (MIN_GAP == 0) ? ST_IDLE : ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (dac_strobe) begin
          if (gap_cnt == GAP_CNT_W'(MIN_GAP - 1)) state_nxt = ST_IDLE;
          else                                    gap_nxt   = gap_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // tx_active stays high through the cycle carrying the final ramp-down output
  assign act_p0 = in_burst(state_nxt) | (state == ST_RAMP_DOWN);

  ad9361_tx_ramp_mul #(
    .DATA_WIDTH       (DATA_WIDTH),
    .LOG2_RAMP_LENGTH (LOG2_RAMP_LENGTH)
  ) u_ramp_mul (
    .x_i  (x_i_p0),
    .x_q  (x_q_p0),
    .gain (gain_p0),
    .y_i  (y_i_p0),
    .y_q  (y_q_p0)
  );

  // Stage 1: registered state and DAC outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      k_cnt      <= '0;
      j_cnt      <= '0;
      gap_cnt    <= '0;
      held_i     <= '0;
      held_q     <= '0;
      valid_out  <= 1'b0;
      data_i_out <= '0;
      data_q_out <= '0;
      tx_active  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      k_cnt     <= k_nxt;
      j_cnt     <= j_nxt;
      gap_cnt   <= gap_nxt;
      valid_out <= dac_strobe;
      underrun  <= urun_p0;
      tx_active <= act_p0;
      if (take) begin
        held_i <= s_data_i;
        held_q <= s_data_q;
      end
      if (dac_strobe) begin
        data_i_out <= y_i_p0;
        data_q_out <= y_q_p0;
      end
    end
  end

endmodule
